// File: rtl/uart_rx_fifo.sv
//------------------------------------------------------------------------------
// uart_rx_fifo
//
// Receive-side byte buffer between the UART receiver and the host register
// read mux. Bytes strobed out of the receiver are queued here. The head byte
// and status are presented on uartdata, and the occupancy on rxcount. Each
// host read access to register UART_ID pops exactly one entry, no matter how
// long the read strobe is held.
//
// Ports:
//   clk        in   system clock, all state changes on the rising edge
//   reset      in   synchronous, active-high reset
//   rx_byte    in   [7:0]  received byte
//   rx_strobe  in   one-cycle pulse, rx_byte is valid this cycle
//   read       in   host read strobe, may be held for several cycles
//   id         in   [15:0] host register id
//   flush      in   synchronous clear of contents and overrun flag
//   uartdata   out  [15:0] {overrun, empty, 6'b0, head_byte}
//   rxcount    out  [15:0] occupancy, zero-extended
//   rx_full    out  occupancy == DEPTH
//   rx_empty   out  occupancy == 0
//------------------------------------------------------------------------------
module uart_rx_fifo #(
  parameter int          DEPTH   = 16,
  parameter int          AW      = 4,
  parameter logic [15:0] UART_ID = 16'h0003
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_byte,
  input  logic        rx_strobe,
  input  logic        read,
  input  logic [15:0] id,
  input  logic        flush,
  output logic [15:0] uartdata,
  output logic [15:0] rxcount,
  output logic        rx_full,
  output logic        rx_empty
);

  localparam logic [AW:0] LP_DEPTH = (AW+1)'(DEPTH);

  logic [7:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_overrun;
  logic          r_read_q;

  logic        w_acc;
  logic        w_acc_edge;
  logic        w_pop;
  logic        w_push;
  logic        w_drop;
  logic        w_empty;
  logic        w_full;
  logic [7:0]  w_head;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == LP_DEPTH);

  // An access is the first cycle in which read targets UART_ID; holding read
  // afterwards does not produce further pops.
  assign w_acc      = read && (id == UART_ID);
  assign w_acc_edge = w_acc && !r_read_q;
  assign w_pop      = w_acc_edge && !w_empty;

  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign w_push = rx_strobe && (!w_full || w_pop);
  assign w_drop = rx_strobe && !w_push;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_overrun <= 1'b0;
      r_read_q  <= 1'b0;
    end else begin
      r_read_q <= w_acc;

      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end

      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - 1'b1;
      end

      // A drop in the same cycle as an access keeps the flag set.
      if (w_drop) begin
        r_overrun <= 1'b1;
      end else if (w_acc_edge) begin
        r_overrun <= 1'b0;
      end
    end
  end

  // NOTE: the storage array has no reset; emptiness is tracked by r_count and
  // the head byte is masked while empty, so stale contents are never visible.
  // Keeping it reset-free lets it map onto plain flops or distributed RAM.
  always_ff @(posedge clk) begin
    if (!reset && !flush && w_push) begin
      r_mem[r_wr_ptr] <= rx_byte;
    end
  end

  // NOTE: combinational blocks assign a default first so no path leaves the
  // output unassigned and no latch is inferred.
  always_comb begin
    w_head = 8'h00;
    if (!w_empty) begin
      w_head = r_mem[r_rd_ptr];
    end
  end

  assign uartdata = {r_overrun, w_empty, 6'b000000, w_head};
  assign rxcount  = {{(16-AW-1){1'b0}}, r_count};
  assign rx_full  = w_full;
  assign rx_empty = w_empty;

endmodule

// File: tb/tb_uart_rx_fifo.sv
//------------------------------------------------------------------------------
// tb_uart_rx_fifo
//
// Directed stimulus with hand-computed expectations, plus a queue-based
// reference model that is compared against the DUT on every falling edge.
//------------------------------------------------------------------------------
module tb_uart_rx_fifo;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_byte;
  logic        rx_strobe;
  logic        read;
  logic [15:0] id;
  logic        flush;
  logic [15:0] uartdata;
  logic [15:0] rxcount;
  logic        rx_full;
  logic        rx_empty;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  uart_rx_fifo #(.DEPTH(DEPTH), .AW(4), .UART_ID(16'h0003)) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_byte   (rx_byte),
    .rx_strobe (rx_strobe),
    .read      (read),
    .id        (id),
    .flush     (flush),
    .uartdata  (uartdata),
    .rxcount   (rxcount),
    .rx_full   (rx_full),
    .rx_empty  (rx_empty)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a byte queue, a sticky overrun flag and the previous
  // access level, all updated from the inputs seen at each rising edge.
  logic [7:0] m_q[$];
  bit         m_ov;
  bit         m_prev_acc;

  always @(posedge clk) begin
    bit acc, first, popping, dropping;
    if (reset || flush) begin
      m_q.delete();
      m_ov       = 1'b0;
      m_prev_acc = 1'b0;
    end else begin
      acc      = read && (id == 16'h0003);
      first    = acc && !m_prev_acc;
      popping  = first && (m_q.size() > 0);
      dropping = rx_strobe && (m_q.size() == DEPTH) && !popping;
      if (popping) void'(m_q.pop_front());
      if (rx_strobe && !dropping) m_q.push_back(rx_byte);
      if (dropping) m_ov = 1'b1;
      else if (first) m_ov = 1'b0;
      m_prev_acc = acc;
    end
  end

  function automatic logic [15:0] model_uartdata();
    logic [7:0] head;
    head = (m_q.size() > 0) ? m_q[0] : 8'h00;
    return {m_ov, (m_q.size() == 0), 6'b000000, head};
  endfunction

  always @(negedge clk) begin
    if (cmp_en) begin
      check("model_uartdata", uartdata, model_uartdata());
      check("model_rxcount",  rxcount,  16'(m_q.size()));
      check("model_full",     {15'd0, rx_full},  {15'd0, (m_q.size() == DEPTH)});
      check("model_empty",    {15'd0, rx_empty}, {15'd0, (m_q.size() == 0)});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    rx_byte   = b;
    rx_strobe = 1'b1;
    tick();
    rx_strobe = 1'b0;
  endtask

  // One complete host access to the UART register followed by release.
  task automatic access();
    read = 1'b1;
    id   = 16'h0003;
    tick();
    read = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; rx_byte = 8'h00; rx_strobe = 1'b0;
    read = 1'b0; id = 16'h0000; flush = 1'b0;
    tick();
    tick();
    cmp_en = 1'b1;
    reset = 1'b0;
    tick();

    // Reset state and first byte
    check("rst_uartdata", uartdata, 16'h4000);
    check("rst_rxcount",  rxcount,  16'd0);
    check("rst_empty",    {15'd0, rx_empty}, 16'd1);
    check("rst_full",     {15'd0, rx_full},  16'd0);
    push(8'hA5);
    check("a5_uartdata", uartdata, 16'h00A5);
    check("a5_rxcount",  rxcount,  16'd1);
    flush = 1'b1; tick(); flush = 1'b0;

    // Held read pops exactly once
    push(8'h11); push(8'h22); push(8'h33);
    read = 1'b1; id = 16'h0003;
    repeat (4) tick();
    read = 1'b0;
    tick();
    check("held_uartdata", uartdata, 16'h0022);
    check("held_rxcount",  rxcount,  16'd2);
    access();
    check("pop2_uartdata", uartdata, 16'h0033);
    access();
    check("pop3_uartdata", uartdata, 16'h4000);

    // Overflow: 17 bytes into 16 entries
    rx_strobe = 1'b1;
    for (int i = 0; i < 17; i++) begin
      rx_byte = 8'(i);
      tick();
    end
    rx_strobe = 1'b0;
    check("ovf_rxcount",  rxcount,  16'd16);
    check("ovf_full",     {15'd0, rx_full}, 16'd1);
    check("ovf_uartdata", uartdata, 16'h8000);
    access();
    check("ovfpop_uartdata", uartdata, 16'h0001);
    check("ovfpop_rxcount",  rxcount,  16'd15);

    // Full with simultaneous push and pop
    push(8'h11);
    check("refill_rxcount", rxcount, 16'd16);
    rx_byte = 8'h77; rx_strobe = 1'b1; read = 1'b1; id = 16'h0003;
    tick();
    rx_strobe = 1'b0; read = 1'b0;
    tick();
    check("fullpp_rxcount",  rxcount,  16'd16);
    check("fullpp_uartdata", uartdata, 16'h0002);
    repeat (15) access();
    check("fullpp_head77", uartdata, 16'h0077);
    check("fullpp_cnt1",   rxcount,  16'd1);
    access();

    // Pointer wrap with simultaneous push/pop pairs
    push(8'h40);
    for (int i = 1; i <= 40; i++) begin
      rx_byte = 8'(8'h40 + i); rx_strobe = 1'b1; read = 1'b1; id = 16'h0003;
      tick();
      rx_strobe = 1'b0; read = 1'b0;
      tick();
      check("wrap_head", uartdata, {8'h00, 8'(8'h40 + i)});
    end
    access();
    check("wrap_rxcount", rxcount, 16'd0);

    // Empty with simultaneous push and access: pop suppressed, no retrigger
    rx_byte = 8'h5C; rx_strobe = 1'b1; read = 1'b1; id = 16'h0003;
    tick();
    rx_strobe = 1'b0;
    tick();
    check("emptypp_uartdata", uartdata, 16'h005C);
    read = 1'b0;
    tick();

    // Other register ids do not pop
    read = 1'b1; id = 16'h0002; tick(); read = 1'b0; tick();
    read = 1'b1; id = 16'h0004; tick(); read = 1'b0; tick();
    check("wrongid_rxcount",  rxcount,  16'd1);
    check("wrongid_uartdata", uartdata, 16'h005C);

    // Flush beats a coincident push
    rx_byte = 8'h99; rx_strobe = 1'b1; flush = 1'b1;
    tick();
    rx_strobe = 1'b0; flush = 1'b0;
    check("flush_rxcount",  rxcount,  16'd0);
    check("flush_uartdata", uartdata, 16'h4000);

    // Reset with read held: the first post-reset edge is the access edge
    // (empty, so no pop); bytes pushed while still held are not popped.
    push(8'hAA);
    read = 1'b1; id = 16'h0003; reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    push(8'hB1); push(8'hB2);
    check("rsthold_rxcount", rxcount, 16'd2);
    read = 1'b0;
    tick();
    access();
    check("rsthold_uartdata", uartdata, 16'h00B2);
    check("rsthold_cnt",      rxcount,  16'd1);

    tick();
    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
